one_second_counter: RTL and testbench
=====================================

# one_second_counter

Elapsed-seconds counter for the activity-tracker datapath. It divides the 100 MHz system clock down to a 1 Hz tick while counting is enabled. It accumulates those ticks into an 8-bit seconds count that feeds the display and statistics logic. Counting pauses, without losing the partial second, whenever the enable is low.

## Interface
Parameters:
- TICKS_PER_SEC, default 100_000_000: clock cycles per counted second. Must be ≥ 2. Benches override it with a small value (e.g. 10).

Ports:
- CLK  input  1  system clock, 100 MHz, rising-edge active
- RESET  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high
- START_COUNTING  input  1  count enable, level-sensitive; high = count, low = pause
- NumOfSec  output  8  elapsed whole seconds, unsigned, registered

## Operation
- Internal prescaler, unsigned, width ceil(log2(TICKS_PER_SEC)) bits, range 0..TICKS_PER_SEC-1.
- An "enabled edge" is a rising CLK edge where RESET=0 and START_COUNTING=1.
- On each enabled edge:
  - prescaler < TICKS_PER_SEC-1: prescaler increments; NumOfSec holds.
  - prescaler = TICKS_PER_SEC-1: prescaler returns to 0; NumOfSec increments by 1.
- On an edge with RESET=0 and START_COUNTING=0, prescaler and NumOfSec both hold (pause). The partial second is retained and resumes on re-enable.
- NumOfSec wraps modulo 256: 255 + 1 → 0. There is no saturation and no overflow flag.
- RESET has priority over START_COUNTING. On any edge with RESET=1, prescaler ← 0 and NumOfSec ← 0, regardless of enable.
- There is no other state and no state machine beyond the two counters.

## Timing
- Reset value: NumOfSec = 0, prescaler = 0. Reset takes effect on the first rising edge sampling RESET=1.
- Before the first reset edge, NumOfSec must still power up as 0, using register initial value 0.
- Latency from reset or zero prescaler:
  - NumOfSec becomes 1 immediately after the TICKS_PER_SEC-th enabled edge.
  - NumOfSec becomes N after N·TICKS_PER_SEC enabled edges.
- Disabled edges do not count toward latency. Gaps in START_COUNTING stretch the wall-clock time but not the edge count.
- NumOfSec changes only on a rising CLK edge. It changes by exactly +1 (or 255→0), and at most once per TICKS_PER_SEC edges.
- START_COUNTING is sampled on the edge:
  - Asserting it between edges makes the next edge the first enabled edge.
  - Deasserting it on the same edge as terminal count suppresses that increment.
- RESET mid-second discards the partial second. After reset release, a full TICKS_PER_SEC enabled edges are needed for the next increment.
- With defaults at 100 MHz, one second = 100,000,000 cycles = 1.000 s. Full wrap = 256 s.

## Test plan
All scenarios use TICKS_PER_SEC=10 and a 10 ns clock.
- Reset: hold RESET=1 for 2 edges with START_COUNTING=1 → NumOfSec=0 throughout; no increment while RESET=1.
- Basic count:
  - Release RESET, assert START_COUNTING at t=20 ns → NumOfSec=1 after exactly 10 enabled edges.
  - Then NumOfSec=5 after 50 enabled edges; each step is exactly 10 edges apart.
- Pause: enable for 7 edges, deassert for 20 edges, re-enable → NumOfSec stays 0 during pause, becomes 1 after 3 more enabled edges.
- Wrap: run 2560 enabled edges from reset → NumOfSec reaches 255 at edge 2550 and returns to 0 at edge 2560.
- Mid-operation reset:
  - At NumOfSec=3 with prescaler=6, pulse RESET for one edge while enabled → NumOfSec=0 on that edge.
  - Next increment to 1 occurs 10 enabled edges after RESET falls.
- Never-enabled: START_COUNTING=0 for 1000 edges after reset → NumOfSec remains 0.

Source files
------------

// File: rtl/one_second_counter.sv
// Elapsed-seconds counter: a prescaler divides CLK down to one tick per
// TICKS_PER_SEC enabled edges, and the ticks accumulate into an 8-bit count.
module one_second_counter #(
    parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START_COUNTING,
    output logic [7:0] NumOfSec
);

    localparam int unsigned PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    // Declaration initialisers give a zero count at power-up, before the first reset edge.
    logic [PW-1:0] presc_q = '0;
    logic [PW-1:0] presc_d;
    logic [7:0]    sec_q   = '0;
    logic [7:0]    sec_d;

    always_comb begin
        presc_d = presc_q;
        sec_d   = sec_q;
        if (START_COUNTING) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                sec_d   = sec_q + 8'd1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            presc_q <= '0;
            sec_q   <= '0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
        end
    end

    assign NumOfSec = sec_q;

endmodule

// File: tb/tb_one_second_counter.sv
// Directed bench for one_second_counter with TICKS_PER_SEC = 10 and a 10 ns clock.
module tb_one_second_counter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START_COUNTING;
    logic [7:0] NumOfSec;

    int vectors = 0;
    int miscompares = 0;

    one_second_counter #(.TICKS_PER_SEC(10)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .START_COUNTING (START_COUNTING),
        .NumOfSec       (NumOfSec)
    );

    always #5 CLK = ~CLK;

    // Advance n rising edges; land 1 ns after the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        START_COUNTING = 1'b1;
        #1;
        vectors++;
        if (NumOfSec !== 8'd0) begin
            miscompares++;
            $display("FAIL power_up: got %0d expected 0", NumOfSec);
        end
        for (int e = 1; e <= 2; e++) begin
            tick(1);
            vectors++;
            if (NumOfSec !== 8'd0) begin
                miscompares++;
                $display("FAIL reset_hold edge %0d: got %0d expected 0", e, NumOfSec);
            end
        end
        RESET = 1'b0;
    endtask

    task automatic test_basic_count();
        logic [7:0] exp;
        START_COUNTING = 1'b1;
        for (int e = 1; e <= 50; e++) begin
            tick(1);
            exp = 8'(e / 10);
            vectors++;
            if (NumOfSec !== exp) begin
                miscompares++;
                $display("FAIL basic_count edge %0d: got %0d expected %0d", e, NumOfSec, exp);
            end
        end
    endtask

    task automatic test_pause();
        do_reset();
        START_COUNTING = 1'b1;
        tick(7);
        vectors++;
        if (NumOfSec !== 8'd0) begin
            miscompares++;
            $display("FAIL pause_pre: got %0d expected 0", NumOfSec);
        end
        START_COUNTING = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick(1);
            vectors++;
            if (NumOfSec !== 8'd0) begin
                miscompares++;
                $display("FAIL pause_hold edge %0d: got %0d expected 0", e, NumOfSec);
            end
        end
        START_COUNTING = 1'b1;
        tick(2);
        vectors++;
        if (NumOfSec !== 8'd0) begin
            miscompares++;
            $display("FAIL pause_resume_early: got %0d expected 0", NumOfSec);
        end
        tick(1);
        vectors++;
        if (NumOfSec !== 8'd1) begin
            miscompares++;
            $display("FAIL pause_resume_inc: got %0d expected 1", NumOfSec);
        end
    endtask

    task automatic test_terminal_deassert();
        do_reset();
        START_COUNTING = 1'b1;
        tick(9);
        START_COUNTING = 1'b0;
        tick(6);
        vectors++;
        if (NumOfSec !== 8'd0) begin
            miscompares++;
            $display("FAIL tc_suppressed: got %0d expected 0", NumOfSec);
        end
        START_COUNTING = 1'b1;
        tick(1);
        vectors++;
        if (NumOfSec !== 8'd1) begin
            miscompares++;
            $display("FAIL tc_after_resume: got %0d expected 1", NumOfSec);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        START_COUNTING = 1'b1;
        for (int e = 1; e <= 2560; e++) begin
            tick(1);
            if (e == 10 || e == 2549 || e == 2550 || e == 2559 || e == 2560) begin
                logic [7:0] exp;
                exp = 8'((e / 10) % 256);
                vectors++;
                if (NumOfSec !== exp) begin
                    miscompares++;
                    $display("FAIL wrap edge %0d: got %0d expected %0d", e, NumOfSec, exp);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        START_COUNTING = 1'b1;
        tick(36);
        vectors++;
        if (NumOfSec !== 8'd3) begin
            miscompares++;
            $display("FAIL mid_reset_pre: got %0d expected 3", NumOfSec);
        end
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        vectors++;
        if (NumOfSec !== 8'd0) begin
            miscompares++;
            $display("FAIL mid_reset_clear: got %0d expected 0", NumOfSec);
        end
        tick(9);
        vectors++;
        if (NumOfSec !== 8'd0) begin
            miscompares++;
            $display("FAIL mid_reset_partial_lost: got %0d expected 0", NumOfSec);
        end
        tick(1);
        vectors++;
        if (NumOfSec !== 8'd1) begin
            miscompares++;
            $display("FAIL mid_reset_next_inc: got %0d expected 1", NumOfSec);
        end
    endtask

    task automatic test_never_enabled();
        do_reset();
        START_COUNTING = 1'b0;
        for (int e = 1; e <= 1000; e++) begin
            tick(1);
            if (e % 100 == 0) begin
                vectors++;
                if (NumOfSec !== 8'd0) begin
                    miscompares++;
                    $display("FAIL never_enabled edge %0d: got %0d expected 0", e, NumOfSec);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_pause();
        test_terminal_deassert();
        test_wrap();
        test_mid_reset();
        test_never_enabled();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
